mem_access_seq: RTL and testbench

//   Sequences every memory access of the multicycle CPU. Accepts one request at a time

---
 rtl/mem_access_seq_if.sv | 25 ++
 rtl/mem_access_seq.sv | 98 +++++++++
 tb/tb_mem_access_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: request, memory and response signals of the memory access sequencer
interface mem_access_seq_if;
  logic        req;
  logic [1:0]  req_op;
  logic [1:0]  req_src;
  logic [1:0]  req_size;
  logic [1:0]  addr_lo;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [2:0]  IorD_Sel;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] rdata_out;
  logic        busy;
  logic        done;
  logic        align_err;
  modport master (
    output req, req_op, req_src, req_size, addr_lo, store_data, mem_rdata,
    input  IorD_Sel, mem_wr, mem_wdata, rdata_out, busy, done, align_err
  );
  modport slave (
    input  req, req_op, req_src, req_size, addr_lo, store_data, mem_rdata,
    output IorD_Sel, mem_wr, mem_wdata, rdata_out, busy, done, align_err
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences multicycle-CPU memory accesses (read latency, sub-word RMW, aligned load return); ALIGN_CHECK_EN enables misalignment trapping
module mem_access_seq #(
  parameter int MEM_LAT = 2
) (
  input logic            clk,
  input logic            reset,
  mem_access_seq_if.slave bus
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0]    op, size, addr;
  logic [15:0]   sdata;
  logic [CW-1:0] cnt;
  logic          in_word, mis;
  logic [2:0]    req_sel, sel_nxt;
  logic [31:0]   mask, fill, merged, loaded, wdata_nxt, rdata_nxt;
  logic          wr_nxt, busy_nxt, done_nxt, err_nxt;
  assign in_word = bus.req_size == 2'b00 || bus.req_size == 2'b11;
`ifdef ALIGN_CHECK_EN
  assign mis = (bus.req_op == 2'b01 || bus.req_op == 2'b10) &&
               (bus.req_size == 2'b01 ? bus.addr_lo[0] : in_word && bus.addr_lo != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign req_sel = bus.req_op == 2'b00 ? 3'b000 :
                   bus.req_op == 2'b11 ? 3'b100 :
                   bus.req_src == 2'b01 ? 3'b010 :
                   bus.req_src == 2'b10 ? 3'b011 : 3'b001;
  assign mask   = size == 2'b10 ? 32'h0000_00FF << {addr, 3'b000} :
                  addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
  assign fill   = size == 2'b10 ? {4{sdata[7:0]}} : {2{sdata}};
  assign merged = (bus.mem_rdata & ~mask) | (fill & mask);
  assign loaded = op == 2'b01 && size == 2'b10 ? {24'h0, bus.mem_rdata[{addr, 3'b000} +: 8]} :
                  op == 2'b01 && size == 2'b01 ? {16'h0, addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0]} :
                  bus.mem_rdata;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next-state: word stores skip the read, sub-word stores read then write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !bus.req ? IDLE : mis ? DONE :
                           bus.req_op == 2'b10 && in_word ? WRITE : RD_WAIT;
      RD_WAIT: state_nxt = cnt != '0 ? RD_WAIT : op == 2'b10 ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    sel_nxt   = state_nxt == IDLE ? 3'b000 : state == IDLE ? req_sel : bus.IorD_Sel;
    wr_nxt    = state_nxt == WRITE;
    wdata_nxt = state_nxt != WRITE ? bus.mem_wdata : state == IDLE ? bus.store_data : merged;
    rdata_nxt = state == RD_WAIT && state_nxt == DONE ? loaded : bus.rdata_out;
    busy_nxt  = state_nxt != IDLE;
    done_nxt  = state_nxt == DONE;
    err_nxt   = state == IDLE && bus.req && mis;
  end
  // output registers; async reset drops mem_wr immediately
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.IorD_Sel  <= 3'b000;
      bus.mem_wr    <= 1'b0;
      bus.mem_wdata <= 32'h0;
      bus.rdata_out <= 32'h0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.align_err <= 1'b0;
    end else begin
      bus.IorD_Sel  <= sel_nxt;
      bus.mem_wr    <= wr_nxt;
      bus.mem_wdata <= wdata_nxt;
      bus.rdata_out <= rdata_nxt;
      bus.busy      <= busy_nxt;
      bus.done      <= done_nxt;
      bus.align_err <= err_nxt;
    end
  // request capture and read-latency countdown
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op    <= 2'b00;
      size  <= 2'b00;
      addr  <= 2'b00;
      sdata <= 16'h0;
      cnt   <= '0;
    end else if (state == IDLE && bus.req) begin
      op    <= bus.req_op;
      size  <= bus.req_size;
      addr  <= bus.addr_lo;
      sdata <= bus.store_data[15:0];
      cnt   <= CW'(MEM_LAT - 1);
    end else if (state == RD_WAIT && cnt != '0) begin
      cnt   <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table-driven scoreboard bench for mem_access_seq (MEM_LAT=2)
module tb_mem_access_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mem_access_seq_if bus();
  mem_access_seq #(.MEM_LAT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [1:0]  op, src, size, addr;
    logic [31:0] sdata, rdata;
    logic [2:0]  sel;
    logic [31:0] rout;
    logic        wr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];
  int checks = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic vec_t mk(input logic [1:0] op, src, size, addr, input logic [31:0] sdata, rdata,
                              input logic [2:0] sel, input logic [31:0] rout, input logic wr,
                              input logic [31:0] wdata, input int lat, input logic err);
    vec_t t;
    t.op = op; t.src = src; t.size = size; t.addr = addr; t.sdata = sdata; t.rdata = rdata;
    t.sel = sel; t.rout = rout; t.wr = wr; t.wdata = wdata; t.lat = lat; t.err = err;
    return t;
  endfunction
  task automatic drive(input vec_t t);
    bus.req = 1'b1; bus.req_op = t.op; bus.req_src = t.src; bus.req_size = t.size;
    bus.addr_lo = t.addr; bus.store_data = t.sdata; bus.mem_rdata = t.rdata;
  endtask
  task automatic run(input vec_t t);
    vec_t e;
    int dc, wrs, selbad;
    logic [31:0] wd, rd;
    logic er;
    dc = 0; wrs = 0; selbad = 0; wd = 0; rd = 0; er = 0;
    @(negedge clk);
    drive(t);
    sb.push_back(t);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 1'b0;
      if (bus.mem_wr) begin wrs++; wd = bus.mem_wdata; end
      if (bus.done) begin dc = c; rd = bus.rdata_out; er = bus.align_err; break; end
      if (bus.IorD_Sel !== t.sel || !bus.busy) selbad++;
    end
    e = sb.pop_front();
    chk("done_latency", dc, e.lat);
    chk("rdata_out", rd, e.rout);
    chk("align_err", er, e.err);
    chk("write_count", wrs, e.wr ? 1 : 0);
    if (e.wr) chk("mem_wdata", wd, e.wdata);
    chk("sel_busy_bad_cycles", selbad, 0);
    @(negedge clk);
    chk("after_done_idle", {bus.done, bus.busy, bus.mem_wr, bus.IorD_Sel}, 6'b0);
  endtask
  initial begin
    int dn;
    bus.req = 0; bus.req_op = 0; bus.req_src = 0; bus.req_size = 0;
    bus.addr_lo = 0; bus.store_data = 0; bus.mem_rdata = 0;
    tv.push_back(mk(2'b00, 2'b00, 2'b00, 2'd0, 32'h0, 32'h8C22_0004, 3'b000, 32'h8C22_0004, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b01, 2'b01, 2'b10, 2'd2, 32'h0, 32'hAABB_CCDD, 3'b010, 32'h0000_00BB, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b10, 2'b10, 2'b10, 2'd1, 32'h12, 32'hAABB_CCDD, 3'b011, 32'h0000_00BB, 1, 32'hAABB_12DD, 4, 0));
    tv.push_back(mk(2'b10, 2'b00, 2'b00, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'b001, 32'h0000_00BB, 1, 32'hDEAD_BEEF, 2, 0));
    tv.push_back(mk(2'b01, 2'b11, 2'b01, 2'd2, 32'h0, 32'h1234_5678, 3'b001, 32'h0000_1234, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b10, 2'b01, 2'b01, 2'd0, 32'hABCD_5678, 32'h1122_3344, 3'b010, 32'h0000_1234, 1, 32'h1122_5678, 4, 0));
    tv.push_back(mk(2'b10, 2'b00, 2'b01, 2'd2, 32'h0000_BEEF, 32'h1122_3344, 3'b001, 32'h0000_1234, 1, 32'hBEEF_3344, 4, 0));
    tv.push_back(mk(2'b10, 2'b10, 2'b10, 2'd3, 32'h0000_00FF, 32'h0, 3'b011, 32'h0000_1234, 1, 32'hFF00_0000, 4, 0));
    tv.push_back(mk(2'b01, 2'b00, 2'b10, 2'd3, 32'h0, 32'h1122_3344, 3'b001, 32'h0000_0011, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b01, 2'b00, 2'b10, 2'd0, 32'h0, 32'h1122_3344, 3'b001, 32'h0000_0044, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b11, 2'b01, 2'b10, 2'd3, 32'h0, 32'h8000_0180, 3'b100, 32'h8000_0180, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b00, 2'b10, 2'b01, 2'd2, 32'h0, 32'hCAFE_F00D, 3'b000, 32'hCAFE_F00D, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b01, 2'b00, 2'b11, 2'd0, 32'h0, 32'h0102_0304, 3'b001, 32'h0102_0304, 0, 32'h0, 3, 0));
`ifdef ALIGN_CHECK_EN
    tv.push_back(mk(2'b01, 2'b00, 2'b01, 2'd1, 32'h0, 32'h1234_5678, 3'b001, 32'h0102_0304, 0, 32'h0, 1, 1));
    tv.push_back(mk(2'b10, 2'b00, 2'b00, 2'd2, 32'h5555_5555, 32'h0, 3'b001, 32'h0102_0304, 0, 32'h0, 1, 1));
    tv.push_back(mk(2'b10, 2'b00, 2'b10, 2'd1, 32'h77, 32'h0, 3'b001, 32'h0102_0304, 1, 32'h0000_7700, 4, 0));
`else
    tv.push_back(mk(2'b01, 2'b00, 2'b01, 2'd1, 32'h0, 32'h1234_5678, 3'b001, 32'h0000_5678, 0, 32'h0, 3, 0));
    tv.push_back(mk(2'b10, 2'b00, 2'b00, 2'd2, 32'h5555_5555, 32'h0, 3'b001, 32'h0000_5678, 1, 32'h5555_5555, 2, 0));
    tv.push_back(mk(2'b10, 2'b00, 2'b10, 2'd1, 32'h77, 32'h0, 3'b001, 32'h0000_5678, 1, 32'h0000_7700, 4, 0));
`endif
    tv.push_back(mk(2'b11, 2'b00, 2'b01, 2'd1, 32'h0, 32'h9ABC_DEF0, 3'b100, 32'h9ABC_DEF0, 0, 32'h0, 3, 0));
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.IorD_Sel, bus.mem_wr, bus.busy, bus.done, bus.align_err}, 7'b0);
    chk("reset_wdata", bus.mem_wdata, 32'h0);
    chk("reset_rdata", bus.rdata_out, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    drive(mk(2'b01, 2'b01, 2'b00, 2'd0, 32'h0, 32'h1111_2222, 3'b010, 32'h0, 0, 32'h0, 3, 0));
    @(negedge clk);
    bus.req = 1'b0;
    chk("rdwait_busy_sel", {bus.busy, bus.IorD_Sel}, 4'b1_010);
    #1 reset = 1'b0;
    #1 chk("abort_rdwait", {bus.IorD_Sel, bus.busy, bus.mem_wr}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (6) begin @(negedge clk); if (bus.done || bus.busy) dn++; end
    chk("no_done_after_abort", dn, 0);
    chk("abort_rdata_clear", bus.rdata_out, 32'h0);
    drive(mk(2'b10, 2'b10, 2'b10, 2'd0, 32'h99, 32'h0, 3'b011, 32'h0, 1, 32'h99, 4, 0));
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    chk("write_cycle_mem_wr", bus.mem_wr, 1'b1);
    #1 reset = 1'b0;
    #1 chk("abort_write_mem_wr", {bus.mem_wr, bus.busy}, 2'b0);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (6) begin @(negedge clk); if (bus.done || bus.mem_wr) dn++; end
    chk("no_done_after_write_abort", dn, 0);
    foreach (tv[i]) run(tv[i]);
    @(negedge clk);
    drive(mk(2'b10, 2'b00, 2'b00, 2'd0, 32'hDEAD_BEEF, 32'h0, 3'b001, 32'h0, 1, 32'h0, 2, 0));
    @(negedge clk);
    chk("ws_cycle1", {bus.mem_wr, bus.done}, 2'b10);
    chk("ws_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.req_op = 2'b01;
    @(negedge clk);
    chk("ws_cycle2", {bus.mem_wr, bus.done, bus.busy}, 3'b011);
    @(negedge clk);
    chk("ws_req_ignored_c3", {bus.busy, bus.done}, 2'b00);
    bus.req = 1'b0;
    @(negedge clk);
    chk("ws_req_ignored_c4", {bus.busy, bus.mem_wr}, 2'b00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
